// File: rtl/sccb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sccb_pkg
// Description : Shared SCCB responder types and bus constants.
// Revision    : 1.0  initial release
// ============================================================================
package sccb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DEV_ID    = 4'd1,
        ST_ACK_ID    = 4'd2,
        ST_SUB_ADDR  = 4'd3,
        ST_ACK_SUB   = 4'd4,
        ST_WR_DATA   = 4'd5,
        ST_ACK_DATA  = 4'd6,
        ST_RD_DATA   = 4'd7,
        ST_RD_NA     = 4'd8,
        ST_WAIT_STOP = 4'd9
    } sccb_state_e;

    localparam logic [7:0] SCCB_WR_ID = 8'h42;
    localparam logic [7:0] SCCB_RD_ID = 8'h43;
    localparam logic       ACK_LEVEL  = 1'b0;

    // States in which a STOP arriving part-way through a byte is a violation
    function automatic logic in_byte_state(input sccb_state_e s);
        return (s == ST_DEV_ID) || (s == ST_SUB_ADDR) ||
               (s == ST_WR_DATA) || (s == ST_RD_DATA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sccb_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : sccb_slave_if
// Description : Register-file side of the SCCB responder plus status flags.
// Revision    : 1.0  initial release
// ============================================================================
interface sccb_slave_if;

    logic       reg_wr;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       err;

    modport slave (
        output reg_wr, reg_addr, reg_wdata, busy, err,
        input  reg_rdata
    );

    modport master (
        input  reg_wr, reg_addr, reg_wdata, busy, err,
        output reg_rdata
    );

endinterface
`default_nettype wire

// File: rtl/sccb_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : sccb_line_sync
// Description : scl/sda synchroniser, run-length glitch filter and bus event
//               detection (scl edges, START, STOP).
// Revision    : 1.0  initial release
// ============================================================================
module sccb_line_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic scl,
    input  wire logic sda,
    output logic      scl_f,
    output logic      sda_f,
    output logic      scl_rise,
    output logic      scl_fall,
    output logic      start_det,
    output logic      stop_det
);

    localparam int            CW        = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] C_CNT_MAX = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic [1:0]             w_raw;
    logic [1:0]             w_filt;
    logic [1:0]             r_filt_d;

    // Idle bus is high on both lines, so reset everything to 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
        end
    end

    assign w_raw = {r_sda_sync[SYNC_STAGES-1], r_scl_sync[SYNC_STAGES-1]};

    for (genvar i = 0; i < 2; i++) begin : g_filt
        logic [CW-1:0] r_cnt;
        logic          r_line;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_cnt  <= '0;
                r_line <= 1'b1;
            end else if (w_raw[i] == r_line) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_MAX) begin
                r_line <= w_raw[i];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_filt[i] = r_line;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_filt_d <= 2'b11;
        end else begin
            r_filt_d <= w_filt;
        end
    end

    assign scl_f     = w_filt[0];
    assign sda_f     = w_filt[1];
    assign scl_rise  =  w_filt[0] & ~r_filt_d[0];
    assign scl_fall  = ~w_filt[0] &  r_filt_d[0];
    assign start_det =  w_filt[0] & r_filt_d[0] &  r_filt_d[1] & ~w_filt[1];
    assign stop_det  =  w_filt[0] & r_filt_d[0] & ~r_filt_d[1] &  w_filt[1];

endmodule
`default_nettype wire

// File: rtl/sccb_slave.sv
`default_nettype none
// ============================================================================
// Module      : sccb_slave
// Description : SCCB responder; decodes 3-phase writes and 2-phase
//               write/read cycles onto a single-cycle register-file port.
// Revision    : 1.0  initial release
// ============================================================================
module sccb_slave
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = SCCB_WR_ID[7:1],
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 3
) (
    input  wire logic   clk,
    input  wire logic   rst,
    input  wire logic   scl,
    inout  wire         sda,
    sccb_slave_if.slave rf
);

    localparam logic [7:0] C_WR_ID = {DEV_ADDR, SCCB_WR_ID[0]};
    localparam logic [7:0] C_RD_ID = {DEV_ADDR, SCCB_RD_ID[0]};

    logic        w_scl_f;
    logic        w_sda_f;
    logic        w_scl_rise;
    logic        w_scl_fall;
    logic        w_start;
    logic        w_stop;
    logic        w_sample;
    logic        w_last;
    logic [7:0]  w_byte;
    logic [2:0]  w_done_bits;

    sccb_state_e r_state;
    logic [2:0]  r_bitcnt;
    logic [7:0]  r_rx;
    logic [7:0]  r_tx;
    logic        r_phase;
    logic        r_pend;
    logic        r_is_rd;
    logic        r_sda_oe;

    sccb_line_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_line_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .scl_f     (w_scl_f),
        .sda_f     (w_sda_f),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start),
        .stop_det  (w_stop)
    );

    assign sda = r_sda_oe ? ACK_LEVEL : 1'bz;

    assign w_sample = w_scl_rise & w_scl_f;
    assign w_last   = (r_bitcnt == 3'd7);
    assign w_byte   = {r_rx[6:0], w_sda_f};
    // A STOP's own scl rise is counted as a bit; only bits closed by a fall are real
    assign w_done_bits = r_bitcnt - {2'b00, r_pend};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_bitcnt     <= 3'd0;
            r_rx         <= 8'h00;
            r_tx         <= 8'h00;
            r_phase      <= 1'b0;
            r_pend       <= 1'b0;
            r_is_rd      <= 1'b0;
            r_sda_oe     <= 1'b0;
            rf.reg_wr    <= 1'b0;
            rf.reg_addr  <= 8'h00;
            rf.reg_wdata <= 8'h00;
            rf.busy      <= 1'b0;
            rf.err       <= 1'b0;
        end else begin
            rf.reg_wr <= 1'b0;
            rf.err    <= 1'b0;
            if (w_stop) begin
                if (in_byte_state(r_state) && (w_done_bits != 3'd0)) begin
                    rf.err <= 1'b1;
                end
                r_state  <= ST_IDLE;
                rf.busy  <= 1'b0;
                r_sda_oe <= 1'b0;
                r_bitcnt <= 3'd0;
                r_phase  <= 1'b0;
                r_pend   <= 1'b0;
            end else if (w_start) begin
                r_state  <= ST_DEV_ID;
                rf.busy  <= 1'b1;
                r_sda_oe <= 1'b0;
                r_bitcnt <= 3'd0;
                r_phase  <= 1'b0;
                r_pend   <= 1'b0;
            end else begin
                if (w_scl_fall) begin
                    r_pend <= 1'b0;
                end
                unique case (r_state)
                    ST_IDLE, ST_WAIT_STOP: begin
                        r_sda_oe <= 1'b0;
                    end
                    ST_DEV_ID, ST_SUB_ADDR, ST_WR_DATA: begin
                        if (w_sample) begin
                            r_rx     <= w_byte;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            r_pend   <= ~w_last;
                            if (w_last) begin
                                if (r_state == ST_DEV_ID) begin
                                    if (w_byte == C_WR_ID) begin
                                        r_is_rd <= 1'b0;
                                        r_state <= ST_ACK_ID;
                                    end else if (w_byte == C_RD_ID) begin
                                        r_is_rd <= 1'b1;
                                        r_tx    <= rf.reg_rdata;
                                        r_state <= ST_ACK_ID;
                                    end else begin
                                        r_state <= ST_WAIT_STOP;
                                    end
                                end else if (r_state == ST_SUB_ADDR) begin
                                    rf.reg_addr <= w_byte;
                                    r_state     <= ST_ACK_SUB;
                                end else begin
                                    rf.reg_wdata <= w_byte;
                                    rf.reg_wr    <= 1'b1;
                                    r_state      <= ST_ACK_DATA;
                                end
                            end
                        end
                    end
                    ST_ACK_ID, ST_ACK_SUB, ST_ACK_DATA: begin
                        // First fall starts the ack slot, second fall ends it
                        if (w_scl_fall) begin
                            if (!r_phase) begin
                                r_phase  <= 1'b1;
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_phase  <= 1'b0;
                                r_sda_oe <= 1'b0;
                                if (r_state == ST_ACK_ID) begin
                                    if (r_is_rd) begin
                                        r_sda_oe <= (r_tx[7] == ACK_LEVEL);
                                        r_state  <= ST_RD_DATA;
                                    end else begin
                                        r_state  <= ST_SUB_ADDR;
                                    end
                                end else if (r_state == ST_ACK_SUB) begin
                                    r_state <= ST_WR_DATA;
                                end else begin
                                    r_state <= ST_WAIT_STOP;
                                end
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        if (w_sample) begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                            r_pend   <= ~w_last;
                            if (w_last) begin
                                r_phase <= 1'b1;
                            end
                        end else if (w_scl_fall) begin
                            if (r_phase) begin
                                r_phase  <= 1'b0;
                                r_sda_oe <= 1'b0;
                                r_state  <= ST_RD_NA;
                            end else begin
                                r_sda_oe <= (r_tx[6] == ACK_LEVEL);
                                r_tx     <= {r_tx[6:0], 1'b0};
                            end
                        end
                    end
                    ST_RD_NA: begin
                        if (w_sample) begin
                            r_state <= ST_WAIT_STOP;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
